// File: rtl/dec4_rr_arbiter.sv
// Arbiter sharing one 2-to-4 decoder among four requesters: registered select/disable,
// one idle cycle between owners, hold timeout under contention. ARB_FIXED_PRIO_EN selects fixed priority.
module dec4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       A0,
    output logic       A1,
    output logic       E,
    output logic [3:0] gnt,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [1:0]       sel;
    logic [CNT_W-1:0] hold_cnt;
    logic [3:0]       req_k;
    logic [3:0]       others;
    logic             found;
    logic [1:0]       win;
    logic             timeout;
    logic             release_now;

`ifndef ARB_FIXED_PRIO_EN
    logic [1:0] last;
`endif

    // req_k[k] is requester k; the external bus is bit-reversed.
    assign req_k  = {req[0], req[1], req[2], req[3]};
    assign others = req_k & ~(4'b0001 << sel);
    assign {A1, A0} = sel;

    always_comb begin
        logic [1:0] k;
        found = 1'b0;
        win   = 2'b00;
        k     = 2'b00;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 3; i >= 0; i--) begin
            k = i[1:0];
            if (req_k[k]) begin
                found = 1'b1;
                win   = k;
            end
        end
        timeout = 1'b0;
`else
        // Walk the search order backwards so the earliest candidate is written last.
        for (int i = 4; i >= 1; i--) begin
            k = last + i[1:0];
            if (req_k[k]) begin
                found = 1'b1;
                win   = k;
            end
        end
        timeout = (hold_cnt == HOLD_MAX) && (|others);
`endif
        release_now = done || !req_k[sel] || timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            E        <= 1'b1;
            sel      <= 2'b00;
            gnt      <= 4'b0000;
            busy     <= 1'b0;
            hold_cnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last     <= 2'd3;
`endif
        end else begin
            case (state)
                GRANT: begin
                    if (release_now) begin
                        state <= GAP;
                        E     <= 1'b1;
                        gnt   <= 4'b0000;
                        busy  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
                        last  <= sel;
`endif
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    if (found) begin
                        state    <= GRANT;
                        E        <= 1'b0;
                        sel      <= win;
                        gnt      <= 4'b1000 >> win;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        state <= IDLE;
                        E     <= 1'b1;
                        gnt   <= 4'b0000;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
